scan_shift_ctrl: RTL and testbench

SCAN_SHIFT_CTRL -- requirements
Module: scan_shift_ctrl

---
 rtl/scan_pkg.sv | 13 +
 rtl/scan_shift_reg.sv | 51 +++++
 rtl/scan_shift_ctrl.sv | 144 ++++++++++++++
 tb/tb_scan_shift_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the scan shift controller: FSM state encoding and chain limits.
package scan_pkg;

    localparam int MAX_CHAIN_LEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } scan_state_e;

endpackage

// File: rtl/scan_shift_reg.sv
// Scan data path: parallel-load PISO driving SI (registered) and SIPO collecting SO.
module scan_shift_reg #(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 load,
    input  logic                 shift,
    input  logic                 last,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 so,
    output logic                 si,
    output logic [CHAIN_LEN-1:0] cap
);

    logic [CHAIN_LEN-1:0] pat_r;
    logic                 si_r;
    logic [CHAIN_LEN-1:0] cap_r;

    // Latched stimulus rotates MSB-first so SI always presents the bit for the coming cycle
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            pat_r <= {CHAIN_LEN{1'b0}};
            si_r  <= 1'b0;
        end else if (load) begin
            pat_r <= pattern;
            si_r  <= pattern[CHAIN_LEN-1];
        end else if (shift) begin
            pat_r <= {pat_r[CHAIN_LEN-2:0], pat_r[CHAIN_LEN-1]};
            si_r  <= last ? 1'b0 : pat_r[CHAIN_LEN-2];
        end else begin
            pat_r <= pat_r;
            si_r  <= 1'b0;
        end
    end

    // First SO bit sampled ends up in the MSB after a full phase
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            cap_r <= {CHAIN_LEN{1'b0}};
        end else if (shift) begin
            cap_r <= {cap_r[CHAIN_LEN-2:0], so};
        end else begin
            cap_r <= cap_r;
        end
    end

    assign si  = si_r;
    assign cap = cap_r;

endmodule

// File: rtl/scan_shift_ctrl.sv
// Scan chain sequencer: shifts a pattern in while unloading the previous capture, then pulses one capture cycle.
module scan_shift_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] resp,
    output logic                 resp_valid
);

    localparam int                CNT_W    = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    scan_state_e          state_r;
    scan_state_e          state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 last_s;
    logic                 load_s;
    logic                 shift_s;
    logic                 capture_end_s;
    logic                 se_s;
    logic                 busy_s;
    logic                 done_s;
    logic                 se_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 resp_valid_r;
    logic [CHAIN_LEN-1:0] resp_r;
    logic [CHAIN_LEN-1:0] cap_s;

    assign last_s = (cnt_r == CNT_LAST);

    // State register
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort beats start in IDLE and is ignored in DONE
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) state_s = ST_SHIFT;
                else                 state_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (abort)       state_s = ST_IDLE;
                else if (last_s) state_s = ST_CAPTURE;
                else             state_s = ST_SHIFT;
            end
            ST_CAPTURE: begin
                if (abort) state_s = ST_IDLE;
                else       state_s = ST_DONE;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Control strobes and next values of the registered outputs
    always_comb begin
        load_s        = 1'b0;
        shift_s       = 1'b0;
        capture_end_s = 1'b0;
        case (state_r)
            ST_IDLE:    load_s        = start && !abort;
            ST_SHIFT:   shift_s       = !abort;
            ST_CAPTURE: capture_end_s = !abort;
            ST_DONE:    load_s        = 1'b0;
            default:    load_s        = 1'b0;
        endcase
        se_s   = (state_s == ST_SHIFT);
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // Shift index; cleared at every phase boundary so it never runs past the last flop
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (shift_s && !last_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Registered outputs; response is published on entry to DONE
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            se_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            resp_r       <= {CHAIN_LEN{1'b0}};
            resp_valid_r <= 1'b0;
        end else begin
            se_r   <= se_s;
            busy_r <= busy_s;
            done_r <= done_s;
            if (capture_end_s) begin
                resp_r       <= cap_s;
                resp_valid_r <= 1'b1;
            end else begin
                resp_r       <= resp_r;
                resp_valid_r <= resp_valid_r;
            end
        end
    end

    scan_shift_reg #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_shift_reg (
        .CK      (CK),
        .RN      (RN),
        .load    (load_s),
        .shift   (shift_s),
        .last    (last_s),
        .pattern (pattern),
        .so      (SO),
        .si      (SI),
        .cap     (cap_s)
    );

    assign SE         = se_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign resp       = resp_r;
    assign resp_valid = resp_valid_r;

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// Randomised scoreboard bench for scan_shift_ctrl driving a 4-flop model chain whose functional D is ~Q.
module tb_scan_shift_ctrl;

    localparam int N = 4;

    logic         CK = 1'b0;
    logic         RN = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] pattern = '0;
    logic         SO;
    logic         SE, SI, busy, done, resp_valid;
    logic [N-1:0] resp;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [N-1:0] resp;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    bit           exp_se[int];
    bit           exp_si[int];
    bit           exp_busy[int];
    logic [N-1:0] model_chain = '0;
    logic [N-1:0] exp_resp_hold = '0;
    bit           rv_exp = 1'b0;
    bit           mon_done;
    exp_t         mon_e;

    logic [N-1:0] chain;
    int           se_run;

    scan_shift_ctrl #(.CHAIN_LEN(N)) dut (
        .CK         (CK),
        .RN         (RN),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .SO         (SO),
        .SE         (SE),
        .SI         (SI),
        .busy       (busy),
        .done       (done),
        .resp       (resp),
        .resp_valid (resp_valid)
    );

    always #5 CK = ~CK;

    always @(posedge CK) cyc <= cyc + 1;

    // Scan chain under test: shifts with SE, takes D=~Q only on the cycle after a full shift phase
    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            chain  <= '0;
            se_run <= 0;
        end else if (SE) begin
            chain  <= {chain[N-2:0], SI};
            se_run <= se_run + 1;
        end else begin
            if (se_run == N) chain <= ~chain;
            se_run <= 0;
        end
    end
    assign SO = chain[N-1];

    task automatic check_bit(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Chain contents after m shifts of pattern p (MSB first) into a chain holding old
    function automatic logic [N-1:0] shifted(input logic [N-1:0] old, input logic [N-1:0] p, input int m);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            if (i < m) r[i] = p[N-m+i];
            else       r[i] = old[i-m];
        end
        return r;
    endfunction

    // Monitor: per-cycle waveform expectations plus scoreboard pop on each expected done
    always @(negedge CK) begin
        mon_done = (sb.size() > 0) && (sb[0].cyc == cyc);
        check_bit("SE", SE, exp_se.exists(cyc) ? exp_se[cyc] : 1'b0);
        check_bit("SI", SI, exp_si.exists(cyc) ? exp_si[cyc] : 1'b0);
        check_bit("busy", busy, exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0);
        check_bit("done", done, mon_done);
        if (mon_done) begin
            mon_e = sb.pop_front();
            exp_resp_hold = mon_e.resp;
            rv_exp = 1'b1;
        end
        check_vec("resp", resp, exp_resp_hold);
        check_bit("resp_valid", resp_valid, rv_exp);
    end

    task automatic idle(input int n);
        start = 1'b0;
        abort = 1'b0;
        repeat (n) begin
            @(posedge CK); #1;
            pattern = N'($urandom);
        end
    endtask

    // abort_k: -1 none, 0..N-1 abort in SHIFT cycle k, N abort in CAPTURE; noise: 0 quiet, 1 random start, 2 start held
    task automatic run_seq(input logic [N-1:0] p, input int abort_k, input int noise);
        int c0;
        int last;
        c0 = cyc;
        start = 1'b1;
        abort = 1'b0;
        pattern = p;
        if (abort_k < 0)       last = c0 + N + 2;
        else if (abort_k >= N) last = c0 + N + 1;
        else                   last = c0 + 1 + abort_k;
        for (int k = 0; k < N; k++) begin
            if (abort_k < 0 || k <= abort_k) begin
                exp_se[c0+1+k] = 1'b1;
                exp_si[c0+1+k] = p[N-1-k];
            end
        end
        for (int c = c0 + 1; c <= last; c++) exp_busy[c] = 1'b1;
        if (abort_k < 0) begin
            sb.push_back('{resp: model_chain, cyc: c0 + N + 2});
            model_chain = ~p;
        end else if (abort_k >= N) begin
            model_chain = ~p;
        end else begin
            model_chain = shifted(model_chain, p, abort_k + 1);
        end
        while (cyc < last) begin
            @(posedge CK); #1;
            if (noise == 2)      start = 1'b1;
            else if (noise == 1) start = 1'($urandom_range(0, 1));
            else                 start = 1'b0;
            pattern = N'($urandom);
            if (cyc == last && abort_k >= 0)     abort = 1'b1;
            else if (cyc == last && noise != 0)  abort = 1'($urandom_range(0, 1));
            else                                 abort = 1'b0;
        end
        @(posedge CK); #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int           c0;
        int           sel;
        int           ak;
        logic [N-1:0] p;

        #2 RN = 1'b0;
        #1;
        check_bit("reset_SE", SE, 1'b0);
        check_bit("reset_SI", SI, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_vec("reset_resp", resp, '0);
        check_bit("reset_resp_valid", resp_valid, 1'b0);
        repeat (2) @(posedge CK);
        #1 RN = 1'b1;
        idle(2);

        run_seq(4'b1010, -1, 0);
        run_seq(4'b0000, -1, 0);
        idle(1);
        run_seq(4'b0110, 2, 0);
        idle(2);

        start = 1'b1;
        abort = 1'b1;
        pattern = 4'b1111;
        repeat (3) begin
            @(posedge CK); #1;
            check_bit("start_abort_idle_busy", busy, 1'b0);
        end
        idle(1);

        run_seq(4'b1100, N, 0);
        idle(1);
        for (int i = 0; i < 3; i++) run_seq(N'($urandom), -1, 2);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 5);
            p = N'($urandom);
            if (sel == 0)      ak = $urandom_range(0, N - 2);
            else if (sel == 1) ak = N;
            else               ak = -1;
            run_seq(p, ak, $urandom_range(0, 1));
            idle($urandom_range(0, 2));
        end
        idle(2);

        p = 4'b1001;
        c0 = cyc;
        start = 1'b1;
        pattern = p;
        exp_se[c0+1] = 1'b1;
        exp_si[c0+1] = p[N-1];
        exp_busy[c0+1] = 1'b1;
        @(posedge CK); #1;
        start = 1'b0;
        @(posedge CK); #1;
        RN = 1'b0;
        exp_se.delete();
        exp_si.delete();
        exp_busy.delete();
        sb.delete();
        model_chain = '0;
        exp_resp_hold = '0;
        rv_exp = 1'b0;
        #1;
        check_bit("midreset_SE", SE, 1'b0);
        check_bit("midreset_SI", SI, 1'b0);
        check_bit("midreset_busy", busy, 1'b0);
        check_bit("midreset_done", done, 1'b0);
        check_vec("midreset_resp", resp, '0);
        check_bit("midreset_resp_valid", resp_valid, 1'b0);
        @(posedge CK); #1;
        RN = 1'b1;
        run_seq(4'b0111, -1, 0);
        idle(3);
        check_bit("scoreboard_drained", sb.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
